matmul_fx_stream: RTL and testbench

//  Parametrised signed fixed-point matrix multiplier C = A x B (optionally C += A x B) for the matrix datapath.

---
 rtl/matmul_fx_stream.sv | 219 +++++++++++++++++++++
 tb/tb_matmul_fx_stream.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_fx_stream.sv
// matmul_fx_stream
//   Signed fixed-point matrix multiplier C = A x B, or C += A x B when the
//   operand set arrives with in_accum=1. There is one MAC lane per result
//   column. The lanes walk row i and inner index k together, so a full
//   result takes ROWS_A*COLS_A cycles. Each result is saturated to OUT_W,
//   and each element has its own overflow flag.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-low reset
//   clear          synchronous abort: back to IDLE, result registers zeroed
//   in_valid/ready operand-set handshake; in_ready is high only in IDLE
//   in_accum       captured with the operands: 1 accumulates onto the last C
//   in_a           A, row-major, element (0,0) in the MSBs
//   in_b           B, column-major, element (0,0) in the MSBs
//   out_valid/ready result handshake; out_valid is high only in DONE
//   out_c          C, row-major, element (0,0) in the MSBs
//   out_sat        per-element saturation flag, MSB = element (0,0)
//   busy           high while the MAC lanes are running
module matmul_fx_stream #(
  parameter int ROWS_A = 2,
  parameter int COLS_A = 2,
  parameter int COLS_B = 2,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_accum,
  input  logic [ROWS_A*COLS_A*DATA_W-1:0]  in_a,
  input  logic [COLS_A*COLS_B*DATA_W-1:0]  in_b,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ROWS_A*COLS_B*OUT_W-1:0]   out_c,
  output logic [ROWS_A*COLS_B-1:0]         out_sat,
  output logic                             busy
);

  localparam int NA  = ROWS_A * COLS_A;
  localparam int NB  = COLS_A * COLS_B;
  localparam int NC  = ROWS_A * COLS_B;
  localparam int PW  = 2 * DATA_W;
  localparam int I_W = (ROWS_A > 1) ? $clog2(ROWS_A) : 1;
  localparam int K_W = (COLS_A > 1) ? $clog2(COLS_A) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                    state_q, state_d;
  logic [NA*DATA_W-1:0]      a_q, a_d;
  logic [NB*DATA_W-1:0]      b_q, b_d;
  logic                      accum_q, accum_d;
  logic [I_W-1:0]            i_q, i_d;
  logic [K_W-1:0]            k_q, k_d;
  logic signed [ACC_W-1:0]   acc_q [COLS_B];
  logic signed [ACC_W-1:0]   acc_d [COLS_B];
  logic signed [OUT_W-1:0]   c_q   [ROWS_A][COLS_B];
  logic signed [OUT_W-1:0]   c_d   [ROWS_A][COLS_B];
  logic                      sat_q [ROWS_A][COLS_B];
  logic                      sat_d [ROWS_A][COLS_B];

  logic signed [DATA_W-1:0]  a_arr [ROWS_A][COLS_A];
  logic signed [DATA_W-1:0]  b_arr [COLS_A][COLS_B];
  logic signed [PW-1:0]      prod  [COLS_B];
  logic signed [ACC_W-1:0]   seed  [COLS_B];
  logic signed [ACC_W-1:0]   sum   [COLS_B];
  logic                      last_k, last_i;

  function automatic logic sat_ovf(input logic signed [ACC_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_val(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                  return v[OUT_W-1:0];
  endfunction

  // Unpack the captured operands and pack the result registers onto the
  // ports. Element (0,0) always sits in the most significant slot.
  for (genvar gi = 0; gi < ROWS_A; gi++) begin : g_a_row
    for (genvar gk = 0; gk < COLS_A; gk++) begin : g_a_col
      assign a_arr[gi][gk] = a_q[(NA-1-(gi*COLS_A+gk))*DATA_W +: DATA_W];
    end
  end

  for (genvar gk = 0; gk < COLS_A; gk++) begin : g_b_row
    for (genvar gj = 0; gj < COLS_B; gj++) begin : g_b_col
      assign b_arr[gk][gj] = b_q[(NB-1-(gj*COLS_A+gk))*DATA_W +: DATA_W];
    end
  end

  for (genvar gi = 0; gi < ROWS_A; gi++) begin : g_c_row
    for (genvar gj = 0; gj < COLS_B; gj++) begin : g_c_col
      assign out_c[(NC-1-(gi*COLS_B+gj))*OUT_W +: OUT_W] = c_q[gi][gj];
      assign out_sat[NC-1-(gi*COLS_B+gj)]                = sat_q[gi][gj];
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == MAC);
  assign out_valid = (state_q == DONE);
  assign last_k    = (k_q == K_W'(COLS_A-1));
  assign last_i    = (i_q == I_W'(ROWS_A-1));

  // Lane datapath. At k=0 the accumulator is seeded with the previous C
  // element (accumulate mode) or zero instead of the stale lane value.
  always_comb begin
    for (int j = 0; j < COLS_B; j++) begin
      prod[j] = PW'(a_arr[i_q][k_q]) * PW'(b_arr[k_q][j]);
      if (k_q == '0) seed[j] = accum_q ? ACC_W'(c_q[i_q][j]) : '0;
      else           seed[j] = acc_q[j];
      sum[j] = seed[j] + ACC_W'(prod[j]);
    end
  end

  // Control and result update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    accum_d = accum_q;
    i_d     = i_q;
    k_d     = k_q;
    acc_d   = acc_q;
    c_d     = c_q;
    sat_d   = sat_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          accum_d = in_accum;
          i_d     = '0;
          k_d     = '0;
          state_d = MAC;
          for (int i = 0; i < ROWS_A; i++)
            for (int j = 0; j < COLS_B; j++)
              sat_d[i][j] = 1'b0;
        end
      end
      MAC: begin
        for (int j = 0; j < COLS_B; j++) begin
          if (last_k) begin
            c_d[i_q][j]   = sat_val(sum[j]);
            sat_d[i_q][j] = sat_ovf(sum[j]);
            acc_d[j]      = '0;
          end else begin
            acc_d[j] = sum[j];
          end
        end
        if (last_k) begin
          k_d = '0;
          if (last_i) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort outranks every handshake; partial rows are dropped.
    if (clear) begin
      state_d = IDLE;
      i_d     = '0;
      k_d     = '0;
      for (int j = 0; j < COLS_B; j++) acc_d[j] = '0;
      for (int i = 0; i < ROWS_A; i++)
        for (int j = 0; j < COLS_B; j++) begin
          c_d[i][j]   = '0;
          sat_d[i][j] = 1'b0;
        end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      accum_q <= 1'b0;
      i_q     <= '0;
      k_q     <= '0;
      for (int j = 0; j < COLS_B; j++) acc_q[j] <= '0;
      for (int i = 0; i < ROWS_A; i++)
        for (int j = 0; j < COLS_B; j++) begin
          c_q[i][j]   <= '0;
          sat_q[i][j] <= 1'b0;
        end
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      accum_q <= accum_d;
      i_q     <= i_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_matmul_fx_stream.sv
module tb_matmul_fx_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default 2x2x2, OUT_W=32
  logic         clear, in_valid, in_ready, in_accum, out_valid, out_ready, busy;
  logic [63:0]  in_a, in_b;
  logic [127:0] out_c;
  logic [3:0]   out_sat;

  // 2x2x2, OUT_W=16
  logic         s_clear, s_in_valid, s_in_ready, s_in_accum, s_out_valid, s_out_ready, s_busy;
  logic [63:0]  s_in_a, s_in_b;
  logic [63:0]  s_out_c;
  logic [3:0]   s_out_sat;

  // 3x4x2, OUT_W=32
  logic         r_clear, r_in_valid, r_in_ready, r_in_accum, r_out_valid, r_out_ready, r_busy;
  logic [191:0] r_in_a;
  logic [127:0] r_in_b;
  logic [191:0] r_out_c;
  logic [5:0]   r_out_sat;

  logic [127:0] q_c[$];
  logic [3:0]   q_s[$];
  logic [63:0]  q16_c[$];
  logic [3:0]   q16_s[$];
  logic [191:0] q3_c[$];
  logic [5:0]   q3_s[$];
  int           q3_t[$];

  matmul_fx_stream dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_accum(in_accum), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_c(out_c), .out_sat(out_sat), .busy(busy));

  matmul_fx_stream #(.OUT_W(16)) dut16 (
    .clk(clk), .rst(rst), .clear(s_clear), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_accum(s_in_accum), .in_a(s_in_a), .in_b(s_in_b), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_c(s_out_c), .out_sat(s_out_sat), .busy(s_busy));

  matmul_fx_stream #(.ROWS_A(3), .COLS_A(4), .COLS_B(2)) dut3 (
    .clk(clk), .rst(rst), .clear(r_clear), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .in_accum(r_in_accum), .in_a(r_in_a), .in_b(r_in_b), .out_valid(r_out_valid),
    .out_ready(r_out_ready), .out_c(r_out_c), .out_sat(r_out_sat), .busy(r_busy));

  localparam logic [63:0] A_I   = {16'd1, 16'd0, 16'd0, 16'd1};
  localparam logic [63:0] B_1   = {16'd1, 16'd3, 16'd2, 16'd4};
  localparam logic [63:0] B_I   = {16'd1, 16'd0, 16'd0, 16'd1};
  localparam logic [127:0] C_1  = {32'd1, 32'd2, 32'd3, 32'd4};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic acc);
    in_a = a; in_b = b; in_accum = acc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got rdy=%b vld=%b busy=%b exp 1 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (out_c !== '0 || out_sat !== '0) begin
      errors++; $display("FAIL reset_data got c=%h sat=%b exp 0", out_c, out_sat);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_identity();
    int n; logic [127:0] ec; logic [3:0] es;
    q_c.push_back(C_1); q_s.push_back(4'b0);
    send(A_I, B_1, 1'b0);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL ident_busy got busy=%b rdy=%b exp 1 0", busy, in_ready);
    end
    wait_out(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL ident_latency got=%0d exp=4", n); end
    ec = q_c.pop_front(); es = q_s.pop_front();
    checks++;
    if (out_c !== ec || out_sat !== es) begin
      errors++; $display("FAIL ident_c got=%h/%b exp=%h/%b", out_c, out_sat, ec, es);
    end
    handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL ident_release got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_accumulate();
    int n; logic [127:0] ec; logic [3:0] es;
    q_c.push_back({32'd2, 32'd4, 32'd6, 32'd8}); q_s.push_back(4'b0);
    send(A_I, B_1, 1'b1);
    wait_out(n);
    ec = q_c.pop_front(); es = q_s.pop_front();
    checks++;
    if (n !== 4 || out_c !== ec || out_sat !== es) begin
      errors++; $display("FAIL accum_c got=%h/%b n=%0d exp=%h/%b", out_c, out_sat, n, ec, es);
    end
    handshake();
    q_c.push_back({32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0}); q_s.push_back(4'b0);
    send({16'hFFFD, 16'd0, 16'd0, 16'd0}, B_I, 1'b0);
    wait_out(n);
    ec = q_c.pop_front(); es = q_s.pop_front();
    checks++;
    if (out_c !== ec || out_sat !== es) begin
      errors++; $display("FAIL negative_c got=%h/%b exp=%h/%b", out_c, out_sat, ec, es);
    end
    handshake();
  endtask

  task automatic test_saturation();
    int n; logic [63:0] ec; logic [3:0] es;
    logic [63:0] a_set [2]; logic [63:0] exp_set [2];
    a_set[0] = {4{16'h7FFF}}; exp_set[0] = {4{16'h7FFF}};
    a_set[1] = {4{16'h8000}}; exp_set[1] = {4{16'h8000}};
    for (int t = 0; t < 2; t++) begin
      q16_c.push_back(exp_set[t]); q16_s.push_back(4'b1111);
      s_in_a = a_set[t]; s_in_b = {4{16'h7FFF}}; s_in_accum = 1'b0; s_in_valid = 1'b1;
      step();
      s_in_valid = 1'b0;
      n = 0;
      while (!s_out_valid && n < 50) begin step(); n++; end
      ec = q16_c.pop_front(); es = q16_s.pop_front();
      checks++;
      if (s_out_c !== ec || s_out_sat !== es) begin
        errors++; $display("FAIL sat%0d got=%h/%b exp=%h/%b", t, s_out_c, s_out_sat, ec, es);
      end
      s_out_ready = 1'b1; step(); s_out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int n; logic [127:0] ec; logic [3:0] es;
    q_c.push_back(C_1); q_s.push_back(4'b0);
    send(A_I, B_1, 1'b0);
    wait_out(n);
    q_c.push_back({32'd1, 32'd0, 32'd0, 32'd1}); q_s.push_back(4'b0);
    in_a = A_I; in_b = B_I; in_accum = 1'b0; in_valid = 1'b1;
    ec = q_c.pop_front(); es = q_s.pop_front();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_c !== ec || out_sat !== es || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d got=%h rdy=%b vld=%b exp=%h 0 1", c, out_c, in_ready, out_valid, ec);
      end
      step();
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got rdy=%b busy=%b vld=%b exp 1 0 0", in_ready, busy, out_valid);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_accept got busy=%b exp 1", busy); end
    wait_out(n);
    ec = q_c.pop_front(); es = q_s.pop_front();
    checks++;
    if (n !== 4 || out_c !== ec || out_sat !== es) begin
      errors++; $display("FAIL bp_second got=%h n=%0d exp=%h", out_c, n, ec);
    end
    handshake();
  endtask

  task automatic test_clear();
    int n; logic [127:0] ec; logic [3:0] es; logic seen;
    send(A_I, B_1, 1'b0);
    step();
    clear = 1'b1; step(); clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_c !== '0 || out_sat !== '0) begin
      errors++; $display("FAIL clear_state got vld=%b rdy=%b busy=%b c=%h exp 0 1 0 0", out_valid, in_ready, busy, out_c);
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin step(); if (out_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL clear_no_result got vld=1 exp 0"); end
    q_c.push_back(C_1); q_s.push_back(4'b0);
    send(A_I, B_1, 1'b1);
    wait_out(n);
    ec = q_c.pop_front(); es = q_s.pop_front();
    checks++;
    if (out_c !== ec || out_sat !== es) begin
      errors++; $display("FAIL clear_accum got=%h exp=%h", out_c, ec);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int n; logic [127:0] ec; logic [3:0] es;
    send(A_I, B_1, 1'b0);
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_c !== '0 || out_sat !== '0) begin
      errors++; $display("FAIL rst_mid got vld=%b rdy=%b busy=%b c=%h exp 0 1 0 0", out_valid, in_ready, busy, out_c);
    end
    step();
    rst = 1'b1;
    step();
    q_c.push_back(C_1); q_s.push_back(4'b0);
    send(A_I, B_1, 1'b1);
    wait_out(n);
    ec = q_c.pop_front(); es = q_s.pop_front();
    checks++;
    if (out_c !== ec || out_sat !== es) begin
      errors++; $display("FAIL rst_accum got=%h exp=%h", out_c, ec);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int got;
    got = 0;
    r_out_ready = 1'b1;
    fork
      begin : driver
        longint prev [3][2];
        logic signed [15:0] ma [3][4];
        logic signed [15:0] mb [4][2];
        logic [191:0] ec; logic [5:0] es; logic acc; longint s; int w;
        for (int i = 0; i < 3; i++) for (int j = 0; j < 2; j++) prev[i][j] = 0;
        for (int set = 0; set < 8; set++) begin
          for (int i = 0; i < 3; i++) for (int k = 0; k < 4; k++) begin
            ma[i][k] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ma[i][k] = ($urandom_range(0, 1) == 1) ? 16'sh7FFF : 16'sh8000;
          end
          for (int k = 0; k < 4; k++) for (int j = 0; j < 2; j++) begin
            mb[k][j] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) mb[k][j] = ($urandom_range(0, 1) == 1) ? 16'sh7FFF : 16'sh8000;
          end
          acc = (set == 0) ? 1'b0 : 1'($urandom_range(0, 1));
          for (int i = 0; i < 3; i++) for (int k = 0; k < 4; k++)
            r_in_a[(11-(i*4+k))*16 +: 16] = ma[i][k];
          for (int k = 0; k < 4; k++) for (int j = 0; j < 2; j++)
            r_in_b[(7-(j*4+k))*16 +: 16] = mb[k][j];
          for (int i = 0; i < 3; i++) for (int j = 0; j < 2; j++) begin
            s = acc ? prev[i][j] : 0;
            for (int k = 0; k < 4; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
            es[5-(i*2+j)] = 1'b0;
            if (s > 64'sd2147483647) begin s = 64'sd2147483647; es[5-(i*2+j)] = 1'b1; end
            else if (s < -64'sd2147483648) begin s = -64'sd2147483648; es[5-(i*2+j)] = 1'b1; end
            prev[i][j] = s;
            ec[(5-(i*2+j))*32 +: 32] = s[31:0];
          end
          q3_c.push_back(ec); q3_s.push_back(es);
          r_in_accum = acc; r_in_valid = 1'b1;
          w = 0;
          while (!r_in_ready && w < 100) begin step(); w++; end
          step();
          q3_t.push_back(cyc);
        end
        r_in_valid = 1'b0;
      end
      begin : monitor
        int guard; logic [191:0] ec; logic [5:0] es; int t;
        guard = 0;
        while (got < 8 && guard < 1000) begin
          step(); guard++;
          if (r_out_valid) begin
            if (q3_c.size() == 0) begin
              checks++; errors++; $display("FAIL b2b_extra got=%h exp none", r_out_c);
            end else begin
              ec = q3_c.pop_front(); es = q3_s.pop_front(); t = q3_t.pop_front();
              checks++;
              if (r_out_c !== ec || r_out_sat !== es) begin
                errors++; $display("FAIL b2b_c%0d got=%h/%b exp=%h/%b", got, r_out_c, r_out_sat, ec, es);
              end
              checks++;
              if (cyc - t !== 12) begin
                errors++; $display("FAIL b2b_latency%0d got=%0d exp=12", got, cyc - t);
              end
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got !== 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", got); end
    r_out_ready = 1'b0;
  endtask

  initial begin
    clear = 0; in_valid = 0; in_accum = 0; out_ready = 0; in_a = '0; in_b = '0;
    s_clear = 0; s_in_valid = 0; s_in_accum = 0; s_out_ready = 0; s_in_a = '0; s_in_b = '0;
    r_clear = 0; r_in_valid = 0; r_in_accum = 0; r_out_ready = 0; r_in_a = '0; r_in_b = '0;
    test_reset();
    test_identity();
    test_accumulate();
    test_saturation();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
